maze_solver_dfs: RTL

Parametrised depth-first maze solver, the next-generation maze-solver core. It walks a W×H grid held in an external 1-bit-per-cell map memory (1 = wall/visited, 0 = free) from (0,0) to (W-1,H-1). It marks visited cells by writing 1 back to the map, backtracks through an internal direction stack, and reports Done/Fail. After success it replays the found path as a stream of moves under a valid/ready handshake.

---
 rtl/maze_solver_dfs.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/maze_solver_dfs.sv
// maze_solver_dfs: depth-first maze walker over an external 1-bit map, with path replay
module maze_solver_dfs #(
   parameter int W     = 16,
   parameter int H     = 16,
   parameter int XW    = 4,
   parameter int YW    = 4,
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          Start,
   input  logic          Run,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [XW-1:0] mem_x,
   output logic [YW-1:0] mem_y,
   input  logic          mem_dout,
   output logic [XW-1:0] X,
   output logic [YW-1:0] Y,
   output logic          Done,
   output logic          Fail,
   output logic          Overflow,
   output logic [AW-1:0] path_len,
   output logic [1:0]    Move,
   output logic          move_valid,
   input  logic          move_ready
);
   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_INIT   = 4'd1;
   localparam logic [3:0] S_TRY    = 4'd2;
   localparam logic [3:0] S_WAIT   = 4'd3;
   localparam logic [3:0] S_MOVE   = 4'd4;
   localparam logic [3:0] S_BACK   = 4'd5;
   localparam logic [3:0] S_DONE   = 4'd6;
   localparam logic [3:0] S_FAIL   = 4'd7;
   localparam logic [3:0] S_REPLAY = 4'd8;
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [3:0]    state;
   logic [2:0]    dir;
   logic [AW:0]   sp, spm1;
   logic [AW-1:0] ri;
   logic [1:0]    stack [DEPTH];
   logic [1:0]    top;
   logic [XW-1:0] cx, bx;
   logic [YW-1:0] cy, by;
   logic          off, at_goal, full;
   assign spm1     = sp - (AW+1)'(1);
   assign top      = stack[spm1[IW-1:0]];
   assign full     = sp == (AW+1)'(DEPTH);
   assign cx       = dir == 3'd1 ? X + XW'(1) : dir == 3'd3 ? X - XW'(1) : X;
   assign cy       = dir == 3'd0 ? Y - YW'(1) : dir == 3'd2 ? Y + YW'(1) : Y;
   assign bx       = top == 2'd1 ? X - XW'(1) : top == 2'd3 ? X + XW'(1) : X;
   assign by       = top == 2'd0 ? Y + YW'(1) : top == 2'd2 ? Y - YW'(1) : Y;
   assign at_goal  = cx == XW'(W-1) && cy == YW'(H-1);
   assign off      = dir[2] || (dir == 3'd0 && Y == '0) || (dir == 3'd1 && X == XW'(W-1)) ||
                     (dir == 3'd2 && Y == YW'(H-1)) || (dir == 3'd3 && X == '0);
   assign mem_rd   = state == S_TRY && !off;
   assign mem_wr   = state == S_INIT || (state == S_MOVE && !full);
   assign mem_x    = (state == S_TRY || state == S_MOVE) ? cx : X;
   assign mem_y    = (state == S_TRY || state == S_MOVE) ? cy : Y;
   assign move_valid = state == S_REPLAY;
   assign Move     = state == S_REPLAY ? stack[ri[IW-1:0]] : 2'd0;
   assign path_len = sp[AW-1:0];

   // search / replay sequencer; the candidate cell is derived from (X,Y,dir), which hold steady from TRY through MOVE
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         X        <= '0;
         Y        <= '0;
         sp       <= '0;
         ri       <= '0;
         dir      <= '0;
         Done     <= 1'b0;
         Fail     <= 1'b0;
         Overflow <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_FAIL: begin
               if (Start) begin
                  state    <= S_INIT;
                  X        <= '0;
                  Y        <= '0;
                  sp       <= '0;
                  dir      <= '0;
                  Done     <= 1'b0;
                  Fail     <= 1'b0;
                  Overflow <= 1'b0;
               end else if (state == S_DONE && Run) begin
                  state <= S_REPLAY;
                  ri    <= '0;
               end
            end
            S_INIT: state <= S_TRY;
            S_TRY: begin
               if (dir[2]) begin
                  state <= sp == '0 ? S_FAIL : S_BACK;
                  Fail  <= sp == '0;
               end else if (off) dir <= dir + 3'd1;
               else state <= S_WAIT;
            end
            S_WAIT: begin
               dir   <= mem_dout ? dir + 3'd1 : dir;
               state <= mem_dout ? S_TRY : S_MOVE;
            end
            S_MOVE: begin
               if (full) begin
                  Fail     <= 1'b1;
                  Overflow <= 1'b1;
                  state    <= S_FAIL;
               end else begin
                  X     <= cx;
                  Y     <= cy;
                  sp    <= sp + (AW+1)'(1);
                  dir   <= '0;
                  Done  <= at_goal;
                  state <= at_goal ? S_DONE : S_TRY;
               end
            end
            S_BACK: begin
               X     <= bx;
               Y     <= by;
               sp    <= spm1;
               dir   <= {1'b0, top} + 3'd1;
               state <= S_TRY;
            end
            S_REPLAY: begin
               if (move_ready) begin
                  ri    <= ri + AW'(1);
                  state <= ri == spm1[AW-1:0] ? S_DONE : S_REPLAY;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // direction stack: pushed on every committed advance, never reset (contents only read below sp)
   always_ff @(posedge clk) begin
      if (!rst && state == S_MOVE && !full) stack[sp[IW-1:0]] <= dir[1:0];
   end
endmodule
